// File: rtl/pulse_meter.sv
// Pulse-line meter: synchronizes an async pulse input and measures high width,
// period and completed-period count in clock cycles, strobing valid per period.
module pulse_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] width,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] wcnt_q, pcnt_q, shadow_q;
  logic [WIDTH-1:0] width_q, period_q, count_q;
  logic             valid_q, overflow_q, busy_q;
  logic             rise, fall;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] x);
    return (x == MAX) ? x : x + ONE;
  endfunction

  // Overflow flags any increment attempted while a counter already sits at MAX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      wcnt_q     <= '0;
      pcnt_q     <= '0;
      shadow_q   <= '0;
      width_q    <= '0;
      period_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s1_q    <= signal;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      valid_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= ARMED;
              busy_q     <= 1'b1;
              count_q    <= '0;
              overflow_q <= 1'b0;
            end
          end
          ARMED: begin
            if (rise) begin
              state_q <= HIGH;
              wcnt_q  <= ONE;
              pcnt_q  <= ONE;
            end
          end
          HIGH: begin
            pcnt_q <= sat_inc(pcnt_q);
            if (pcnt_q == MAX) overflow_q <= 1'b1;
            if (fall) begin
              shadow_q <= wcnt_q;
              state_q  <= LOW;
            end else begin
              wcnt_q <= sat_inc(wcnt_q);
              if (wcnt_q == MAX) overflow_q <= 1'b1;
            end
          end
          LOW: begin
            if (rise) begin
              period_q <= pcnt_q;
              width_q  <= shadow_q;
              count_q  <= sat_inc(count_q);
              if (count_q == MAX) overflow_q <= 1'b1;
              valid_q  <= 1'b1;
              wcnt_q   <= ONE;
              pcnt_q   <= ONE;
              state_q  <= HIGH;
            end else begin
              pcnt_q <= sat_inc(pcnt_q);
              if (pcnt_q == MAX) overflow_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign width    = width_q;
  assign period   = period_q;
  assign count    = count_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed + randomized bench for pulse_meter; an 8-bit instance carries the
// main traffic and a 4-bit instance exercises saturation on its own pulse line.
module tb_pulse_meter;

  logic       clock = 1'b0, reset = 1'b1, signal = 1'b0, sig4 = 1'b0;
  logic       start = 1'b0, stop = 1'b0;
  logic [7:0] width, period, count;
  logic       valid, overflow, busy;
  logic [3:0] width4, period4, count4;
  logic       valid4, overflow4, busy4;

  int checks = 0, errors = 0, cyc = 0;
  int hs[32], ls[32];

  typedef struct { int w; int p; int c; int cyc; } rec_t;
  rec_t q[$];
  logic vprev = 1'b0;

  pulse_meter #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .signal(signal), .start(start), .stop(stop),
    .width(width), .period(period), .count(count), .valid(valid),
    .overflow(overflow), .busy(busy));

  pulse_meter #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .signal(sig4), .start(start), .stop(stop),
    .width(width4), .period(period4), .count(count4), .valid(valid4),
    .overflow(overflow4), .busy(busy4));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Record every valid strobe and insist it never lasts two cycles.
  always @(negedge clock) begin
    if (valid) begin
      q.push_back('{int'(width), int'(period), int'(count), cyc});
      checks++;
      assert (!vprev) else begin
        errors++;
        $error("FAIL valid_double observed=1 expected=0");
      end
    end
    vprev = valid;
  end

  function automatic int sat8(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic pulse_start();
    start = 1'b1; @(negedge clock); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clock); stop = 1'b0;
  endtask

  task automatic drive_segs(input int n);
    for (int i = 0; i < n; i++) begin
      signal = 1'b1; repeat (hs[i]) @(negedge clock);
      signal = 1'b0; repeat (ls[i]) @(negedge clock);
    end
  endtask

  // n high/low segments then a closing rise: expect n measured periods.
  task automatic drive_train(input string tag, input int n);
    q.delete();
    drive_segs(n);
    signal = 1'b1;
    @(negedge clock); @(negedge clock);
    chk({tag, "_lat_pre"}, int'(valid), 0);
    @(negedge clock);
    chk({tag, "_lat_valid"}, int'(valid), 1);
    repeat (2) @(negedge clock);
    signal = 1'b0;
    repeat (4) @(negedge clock);
    chk({tag, "_nvalid"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), q[i].w, sat8(hs[i]));
      chk($sformatf("%s_p%0d", tag, i), q[i].p, sat8(hs[i] + ls[i]));
      chk($sformatf("%s_c%0d", tag, i), q[i].c, sat8(i + 1));
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clock);
    chk("rst_width", int'(width), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clock);

    // pulses without start are ignored
    for (int i = 0; i < 10; i++) begin hs[i] = 2; ls[i] = 2; end
    q.delete();
    drive_segs(10);
    repeat (4) @(negedge clock);
    chk("idle_nvalid", q.size(), 0);
    chk("idle_count", int'(count), 0);
    chk("idle_busy", int'(busy), 0);

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1; @(negedge clock);
    start = 1'b0; stop = 1'b0; @(negedge clock);
    chk("startstop_busy", int'(busy), 0);

    // basic 3-high / 5-low train
    pulse_start();
    chk("basic_busy", int'(busy), 1);
    chk("basic_count0", int'(count), 0);
    for (int i = 0; i < 4; i++) begin hs[i] = 3; ls[i] = 5; end
    drive_train("basic", 4);

    // randomized train
    pulse_stop();
    chk("rand_stop_busy", int'(busy), 0);
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      hs[i] = int'($urandom_range(1, 6));
      ls[i] = int'($urandom_range(1, 6));
    end
    drive_train("rand", 20);

    // stop during LOW: outputs hold, no capture
    pulse_stop();
    pulse_start();
    for (int i = 0; i < 2; i++) begin hs[i] = 3; ls[i] = 4; end
    drive_train("stopmid", 2);
    pulse_stop();
    signal = 1'b1;
    repeat (6) @(negedge clock);
    chk("stopmid_nvalid", q.size(), 2);
    chk("stopmid_count", int'(count), 2);
    chk("stopmid_width", int'(width), 3);
    chk("stopmid_period", int'(period), 7);
    chk("stopmid_busy", int'(busy), 0);
    signal = 1'b0;
    repeat (3) @(negedge clock);
    pulse_start();
    chk("restart_count", int'(count), 0);
    chk("restart_width_hold", int'(width), 3);
    chk("restart_busy", int'(busy), 1);

    // minimum period 1/1
    for (int i = 0; i < 10; i++) begin hs[i] = 1; ls[i] = 1; end
    drive_train("min", 10);
    for (int i = 1; i < q.size(); i++)
      chk($sformatf("min_spacing%0d", i), q[i].cyc - q[i-1].cyc, 2);

    // saturation on the 4-bit instance
    pulse_stop();
    pulse_start();
    sig4 = 1'b1; repeat (20) @(negedge clock);
    sig4 = 1'b0; repeat (2) @(negedge clock);
    sig4 = 1'b1; repeat (3) @(negedge clock);
    chk("sat_valid", int'(valid4), 1);
    chk("sat_width", int'(width4), 15);
    chk("sat_period", int'(period4), 15);
    chk("sat_count", int'(count4), 1);
    chk("sat_overflow", int'(overflow4), 1);
    sig4 = 1'b0; repeat (3) @(negedge clock);
    sig4 = 1'b1; repeat (3) @(negedge clock);
    chk("sat2_valid", int'(valid4), 1);
    chk("sat2_width", int'(width4), 3);
    chk("sat2_period", int'(period4), 6);
    chk("sat2_count", int'(count4), 2);
    chk("sat2_overflow", int'(overflow4), 1);
    sig4 = 1'b0; repeat (3) @(negedge clock);
    pulse_stop();
    pulse_start();
    chk("sat_clr_overflow", int'(overflow4), 0);
    chk("sat_clr_count", int'(count4), 0);
    chk("sat_clr_width_hold", int'(width4), 3);

    // asynchronous reset mid-HIGH
    signal = 1'b1;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_width", int'(width), 0);
    chk("arst_period", int'(period), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_overflow", int'(overflow), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_width4", int'(width4), 0);
    @(negedge clock);
    reset = 1'b0;
    signal = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) begin hs[i] = 2; ls[i] = 2; end
    drive_segs(3);
    signal = 1'b1;
    repeat (5) @(negedge clock);
    chk("post_rst_nvalid", q.size(), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_count", int'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
